// File: rtl/fp_addsub_param.sv
// fp_addsub_param: multi-cycle floating-point adder/subtractor, IDLE/ALIGN/ADD/NORM/ROUND/DONE.
// Define FPADD_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results are truncated.
module fp_addsub_param #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 25,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clock_100kHz,
    input  logic         reset,
    input  logic         start,
    input  logic         op_sub,
    input  logic [W-1:0] op_A_in,
    input  logic [W-1:0] op_B_in,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] data_out,
    output logic [3:0]   status_out
);
    // Working mantissa layout: hidden bit, fraction, guard, round, sticky.
    localparam int MW = MAN_W + 4;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t           state_q;
    logic             sign_a_q, sign_b_q, zero_q, unf_q, ready_q, done_q;
    logic [EXP_W-1:0] exp_q, exp_b_q;
    logic [MW-1:0]    man_a_q, man_b_q;
    logic [MW:0]      sum_q;
    logic [W-1:0]     data_q;
    logic [3:0]       status_q;

    logic             sign_a_d, sign_b_d, swap_d;
    logic [EXP_W-1:0] exp_a_d, exp_b_d;
    logic [MW-1:0]    man_a_d, man_b_d;
    logic [MW:0]      sum_d;

    function automatic logic [MW-1:0] align_shift(input logic [MW-1:0] m, input logic [EXP_W-1:0] d);
        logic [MW-1:0] sh;
        logic          sticky;
        sh     = '0;
        sticky = 1'b0;
        if (int'(d) >= MW) begin
            sticky = |m;
        end else begin
            sh     = m >> d;
            sticky = |(m & ~({MW{1'b1}} << d));
        end
        return {sh[MW-1:1], sh[0] | sticky};
    endfunction

    // m excludes the hidden bit; returns {status, packed result}.
    function automatic logic [W+3:0] round_pack(input logic s, input logic [EXP_W-1:0] e,
                                                input logic [MW-2:0] m, input logic zero,
                                                input logic unf);
        logic [MAN_W-1:0] frac;
        logic [EXP_W:0]   e_r;
        logic             inexact;
`ifdef FPADD_ROUND_NEAREST_EN
        logic [MAN_W:0]   frac_inc;
`endif
        frac    = m[MW-2:3];
        e_r     = {1'b0, e};
        inexact = |m[2:0];
`ifdef FPADD_ROUND_NEAREST_EN
        if (m[2] & (m[1] | m[0] | m[3])) begin
            frac_inc = {1'b0, frac} + 1'b1;
            frac     = frac_inc[MAN_W-1:0];
            e_r      = e_r + {{EXP_W{1'b0}}, frac_inc[MAN_W]};
        end
`endif
        if (zero)
            return {4'b0001, {W{1'b0}}};
        if (e_r >= {1'b0, EXP_ONES})
            return {4'b0010, s, EXP_ONES, {MAN_W{1'b0}}};
        if (unf)
            return {4'b0100, s, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
        return {(inexact ? 4'b1000 : 4'b0001), s, e_r[EXP_W-1:0], frac};
    endfunction

    always_comb begin
        logic             sa, sb;
        logic [EXP_W-1:0] ea, eb;
        logic [MW-1:0]    ma, mb;
        sa = op_A_in[W-1];
        sb = op_B_in[W-1] ^ op_sub;
        ea = op_A_in[W-2:MAN_W];
        eb = op_B_in[W-2:MAN_W];
        ma = (ea != '0) ? {1'b1, op_A_in[MAN_W-1:0], 3'b000} : '0;
        mb = (eb != '0) ? {1'b1, op_B_in[MAN_W-1:0], 3'b000} : '0;
        // Exponent-then-fraction ordering equals an unsigned compare of the magnitude bits.
        swap_d   = op_B_in[W-2:0] > op_A_in[W-2:0];
        sign_a_d = swap_d ? sb : sa;
        sign_b_d = swap_d ? sa : sb;
        exp_a_d  = swap_d ? eb : ea;
        exp_b_d  = swap_d ? ea : eb;
        man_a_d  = swap_d ? mb : ma;
        man_b_d  = swap_d ? ma : mb;
        sum_d    = (sign_a_q == sign_b_q) ? ({1'b0, man_a_q} + {1'b0, man_b_q})
                                          : ({1'b0, man_a_q} - {1'b0, man_b_q});
    end

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            zero_q   <= 1'b0;
            unf_q    <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            exp_q    <= '0;
            exp_b_q  <= '0;
            man_a_q  <= '0;
            man_b_q  <= '0;
            sum_q    <= '0;
            data_q   <= '0;
            status_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sign_a_q <= sign_a_d;
                        sign_b_q <= sign_b_d;
                        exp_q    <= exp_a_d;
                        exp_b_q  <= exp_b_d;
                        man_a_q  <= man_a_d;
                        man_b_q  <= man_b_d;
                        unf_q    <= 1'b0;
                        ready_q  <= 1'b0;
                        state_q  <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    man_b_q <= align_shift(man_b_q, exp_q - exp_b_q);
                    state_q <= S_ADD;
                end
                S_ADD: begin
                    sum_q   <= sum_d;
                    zero_q  <= (sum_d == '0);
                    state_q <= S_NORM;
                end
                S_NORM: begin
                    // Underflow is tested before the hidden bit so a shift into exponent 0 still flags it.
                    if (zero_q) begin
                        state_q <= S_ROUND;
                    end else if (sum_q[MW]) begin
                        sum_q   <= {1'b0, sum_q[MW:2], sum_q[1] | sum_q[0]};
                        exp_q   <= (exp_q == EXP_ONES) ? exp_q : exp_q + 1'b1;
                        state_q <= S_ROUND;
                    end else if (exp_q == '0) begin
                        unf_q   <= 1'b1;
                        state_q <= S_ROUND;
                    end else if (sum_q[MW-1]) begin
                        state_q <= S_ROUND;
                    end else begin
                        sum_q <= sum_q << 1;
                        exp_q <= exp_q - 1'b1;
                    end
                end
                S_ROUND: begin
                    {status_q, data_q} <= round_pack(sign_a_q, exp_q, sum_q[MW-2:0], zero_q, unf_q);
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready      = ready_q;
    assign done       = done_q;
    assign data_out   = data_q;
    assign status_out = status_q;

endmodule

// File: tb/tb_fp_addsub_param.sv
// Scoreboard bench for fp_addsub_param: exact-arithmetic reference model plus directed corner vectors.
module tb_fp_addsub_param;
    localparam int EXP_W = 6;
    localparam int MAN_W = 25;
    localparam int W     = 1 + EXP_W + MAN_W;
`ifdef FPADD_ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic         clock_100kHz = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         op_sub = 1'b0;
    logic [W-1:0] op_A_in = '0;
    logic [W-1:0] op_B_in = '0;
    logic         ready, done;
    logic [W-1:0] data_out;
    logic [3:0]   status_out;

    fp_addsub_param #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clock_100kHz(clock_100kHz),
        .reset(reset),
        .start(start),
        .op_sub(op_sub),
        .op_A_in(op_A_in),
        .op_B_in(op_B_in),
        .ready(ready),
        .done(done),
        .data_out(data_out),
        .status_out(status_out)
    );

    always #5 clock_100kHz = ~clock_100kHz;

    typedef struct {
        logic [W-1:0] d;
        logic [3:0]   st;
        int           lat;
        int           issue;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   dones = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    always @(posedge clock_100kHz) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Exact-value reference: align with unbounded precision, then normalise and round once.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                  output logic [W-1:0] d, output logic [3:0] st, output int lat);
        logic             sa, sb, sx, inexact;
        int               ea, eb, ex, dsh, p, lz, e, sh;
        logic [127:0]     ma, mb, mx, s, kept, dropped, half;
        logic [EXP_W-1:0] e_f;
        sa = a[W-1];
        sb = b[W-1] ^ sub;
        ea = int'(a[W-2:MAN_W]);
        eb = int'(b[W-2:MAN_W]);
        ma = (ea != 0) ? 128'({1'b1, a[MAN_W-1:0]}) : 128'd0;
        mb = (eb != 0) ? 128'({1'b1, b[MAN_W-1:0]}) : 128'd0;
        if (eb > ea || (eb == ea && mb > ma)) begin
            sx = sa; sa = sb; sb = sx;
            ex = ea; ea = eb; eb = ex;
            mx = ma; ma = mb; mb = mx;
        end
        dsh = ea - eb;
        s = (sa == sb) ? ((ma << dsh) + mb) : ((ma << dsh) - mb);
        if (s == 0) begin
            d = '0; st = 4'b0001; lat = 5;
            return;
        end
        p = 0;
        for (int i = 127; i >= 0; i--) begin
            if (s[i]) begin p = i; break; end
        end
        lz = (MAN_W + dsh) - p;
        if (lz > 0 && lz >= ea) begin
            d = {sa, {EXP_W{1'b0}}, {MAN_W{1'b0}}}; st = 4'b0100; lat = 5 + ea;
            return;
        end
        lat = 5 + ((lz > 0) ? lz : 0);
        e = ea - lz;
        if (p > MAN_W) begin
            sh      = p - MAN_W;
            kept    = s >> sh;
            dropped = s & ((128'd1 << sh) - 128'd1);
            half    = 128'd1 << (sh - 1);
        end else begin
            kept    = s << (MAN_W - p);
            dropped = '0;
            half    = '0;
        end
        inexact = (dropped != 0);
        if (RNE && (dropped > half || (dropped == half && dropped != 0 && kept[0]))) begin
            kept = kept + 128'd1;
            if ((kept >> (MAN_W + 1)) != 0) begin
                kept = kept >> 1;
                e    = e + 1;
            end
        end
        if (e >= (1 << EXP_W) - 1) begin
            d = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}}; st = 4'b0010;
        end else begin
            e_f = e[EXP_W-1:0];
            d   = {sa, e_f, kept[MAN_W-1:0]};
            st  = inexact ? 4'b1000 : 4'b0001;
        end
    endfunction

    always @(negedge clock_100kHz) begin
        if (prev_done === 1'b1)
            check("done_one_cycle", done, 0);
        if (done === 1'b1) begin
            dones++;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual data=%0h required no result pending", data_out);
            end else begin
                mon_e = sbq.pop_front();
                check("data", data_out, mon_e.d);
                check("status", status_out, mon_e.st);
                check("latency", cyc - mon_e.issue, mon_e.lat);
                check("ready_low_in_done", ready, 0);
            end
        end
        prev_done = done;
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic use_model, input logic [W-1:0] d_req, input logic [3:0] st_req);
        exp_t         e;
        logic [W-1:0] md;
        logic [3:0]   ms;
        int           ml;
        int           n;
        n = 0;
        while (ready !== 1'b1 && n < 300) begin
            @(negedge clock_100kHz);
            n++;
        end
        if (ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual ready=%b required 1", ready);
            return;
        end
        model(a, b, sub, md, ms, ml);
        e.d     = use_model ? md : d_req;
        e.st    = use_model ? ms : st_req;
        e.lat   = ml;
        e.issue = cyc;
        sbq.push_back(e);
        op_A_in = a;
        op_B_in = b;
        op_sub  = sub;
        start   = 1'b1;
        @(posedge clock_100kHz);
        #1 start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 400) begin
            @(negedge clock_100kHz);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual pending=%0d required 0", sbq.size());
            sbq.delete();
        end
        @(negedge clock_100kHz);
    endtask

    initial begin
        int               ndone;
        int               mode, ea, eb;
        logic [MAN_W-1:0] fa, fb;
        logic             sa, sb, sub;
        logic [W-1:0]     a, b;

        repeat (3) @(negedge clock_100kHz);
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        check("reset_data", data_out, 0);
        check("reset_status", status_out, 0);
        reset = 1'b1;

        issue(32'h3E000000, 32'h3E000000, 1'b0, 1'b0, 32'h40000000, 4'b0001);
        issue(32'h3E000000, 32'h3E000000, 1'b1, 1'b0, 32'h00000000, 4'b0001);
        issue(32'h7C000000, 32'h7C000000, 1'b0, 1'b0, 32'h7E000000, 4'b0010);
        issue(32'h03000000, 32'h02000000, 1'b1, 1'b0, 32'h00000000, 4'b0100);
        issue(32'h3E000000, 32'h0A000000, 1'b0, 1'b0, 32'h3E000000, 4'b1000);
        issue(32'h00000000, 32'h3E123456, 1'b1, 1'b0, 32'hBE123456, 4'b0001);
        issue(32'h00ABCDEF, 32'h01000000, 1'b0, 1'b0, 32'h00000000, 4'b0001);
        drain();

        for (int i = 0; i < 150; i++) begin
            mode = $urandom_range(0, 3);
            case (mode)
                0:       ea = $urandom_range(1, 4);
                1:       ea = $urandom_range(58, 62);
                default: ea = $urandom_range(1, 62);
            endcase
            if ($urandom_range(0, 1) == 1) eb = ea + $urandom_range(0, 2) - 1;
            else                           eb = $urandom_range(1, 62);
            if (eb < 1)  eb = 1;
            if (eb > 62) eb = 62;
            if ($urandom_range(0, 9) == 0)  eb = 0;
            if ($urandom_range(0, 19) == 0) ea = 0;
            fa  = MAN_W'($urandom);
            fb  = ($urandom_range(0, 3) == 0) ? fa : MAN_W'($urandom);
            sa  = 1'($urandom_range(0, 1));
            sb  = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            a   = {sa, EXP_W'(ea), fa};
            b   = {sb, EXP_W'(eb), fb};
            issue(a, b, sub, 1'b1, '0, '0);
        end
        drain();

        // Abort a long normalisation with reset after a start issued while busy.
        issue(32'h3E000000, 32'h3E000000, 1'b0, 1'b0, 32'h40000000, 4'b0001);
        drain();
        ndone = dones;
        op_A_in = {1'b0, EXP_W'(40), MAN_W'(0)};
        op_B_in = {1'b0, EXP_W'(40), MAN_W'(1)};
        op_sub  = 1'b1;
        start   = 1'b1;
        @(posedge clock_100kHz);
        #1 start = 1'b0;
        repeat (2) @(negedge clock_100kHz);
        op_A_in = 32'h3E000000;
        op_B_in = 32'h3E000000;
        op_sub  = 1'b0;
        start   = 1'b1;
        @(posedge clock_100kHz);
        #1 start = 1'b0;
        repeat (4) @(negedge clock_100kHz);
        reset = 1'b0;
        #1;
        check("midop_reset_ready", ready, 1);
        check("midop_reset_done", done, 0);
        check("midop_reset_data", data_out, 0);
        check("midop_reset_status", status_out, 0);
        repeat (2) @(negedge clock_100kHz);
        reset = 1'b1;
        repeat (40) @(negedge clock_100kHz);
        check("busy_start_ignored", dones, ndone);
        check("post_reset_ready", ready, 1);
        check("post_reset_data", data_out, 0);

        issue(32'h3E000000, 32'h0A000000, 1'b0, 1'b0, 32'h3E000000, 4'b1000);
        issue(32'h3E000000, 32'h3E000000, 1'b0, 1'b0, 32'h40000000, 4'b0001);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual cycles=%0d required completion", cyc);
        $fatal(1);
    end

endmodule

// File: doc/fp_addsub_param.md
FP_ADDSUB_PARAM -- requirements
Module: fp_addsub_param

Interface
REQ-001 Parameter EXP_W, default 6: exponent field width, 2..10.
REQ-002 Parameter MAN_W, default 25: stored fraction width, hidden bit excluded, 4..52.
REQ-003 Derived W = 1+EXP_W+MAN_W: bit W-1 sign, next EXP_W bits exponent, low MAN_W bits fraction.
REQ-004 clock_100kHz  in  1  clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low.
REQ-006 start  in  1  request; accepted only when ready=1.
REQ-007 op_sub  in  1  0: A+B, 1: A-B; sampled with start.
REQ-008 op_A_in, op_B_in  in  W  operands; sampled with start.
REQ-009 ready  out  1  high in IDLE only.
REQ-010 done  out  1  one-cycle pulse when data_out/status_out are valid.
REQ-011 data_out  out  W  result; held until the next accepted start.
REQ-012 status_out  out  4  one-hot: bit0 exact, bit1 overflow, bit2 underflow, bit3 inexact.

Function
REQ-013 Exponent field 0 means zero (fraction ignored); all-ones means overflow; any other exponent has hidden bit 1.
REQ-014 States: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
REQ-015 IDLE: on start&ready, register the operands; B sign inverted when op_sub=1; larger magnitude (exponent, then fraction) placed in A; go to ALIGN.
REQ-016 ALIGN, 1 cycle: B mantissa right-shifted by d=expA-expB, kept as guard, round and sticky bits; d>MAN_W+2 leaves only sticky=1 (B nonzero).
REQ-017 ADD, 1 cycle: mantissas summed when signs are equal, otherwise B subtracted from A; result sign = sign of A.
REQ-018 NORM: carry-out causes a 1-bit right shift, exp+1 (1 cycle); otherwise a 1-bit left shift, exp-1 per cycle until the hidden bit is 1; bounded at MAN_W+3 cycles.
REQ-019 Zero mantissa after ADD: result +0 (all bits 0), status exact, NORM skipped.
REQ-020 Exponent reaching 0 during NORM: stop; result sign,0,0; status underflow.
REQ-021 Exponent reaching all-ones (NORM or ROUND carry): result sign, all-ones exponent, fraction 0; status overflow.
REQ-022 ROUND, 1 cycle: rounding per REQ-029/030; any nonzero guard/round/sticky sets inexact unless overflow/underflow applies.
REQ-023 Status priority: overflow > underflow > inexact > exact; exactly one bit set.
REQ-024 DONE, 1 cycle: done=1, data_out/status_out updated that cycle; next state IDLE, ready=1 the following cycle.
REQ-025 A zero operand passes the other operand through unchanged (sign per op_sub), exact; both zero gives +0 exact.
REQ-026 start while busy is ignored and not queued; latency start to done is 5+NORM-shift cycles (minimum 5).

Reset
REQ-027 reset low forces IDLE at any time, including mid-operation; data_out=0, status_out=0, done=0, ready=1, internal registers 0.
REQ-028 The first start is accepted on the first rising edge after reset deassertion.

Configuration
REQ-029 Macro FPADD_ROUND_NEAREST_EN defined: ROUND applies round-to-nearest-even; a mantissa carry renormalises with exp+1 in the same cycle.
REQ-030 Macro FPADD_ROUND_NEAREST_EN undefined: truncation; ROUND only evaluates inexact; no increment logic synthesised.

Verification (defaults EXP_W=6, MAN_W=25)
REQ-031 A=0x3E000000, B=0x3E000000, op_sub=0 -> data_out=0x40000000, status=0001, done 5 cycles after start.
REQ-032 A=0x3E000000, B=0x3E000000, op_sub=1 -> data_out=0x00000000, status=0001.
REQ-033 A=0x7C000000, B=0x7C000000, add -> data_out=0x7E000000, status=0010.
REQ-034 A=0x03000000, B=0x02000000, op_sub=1 -> data_out=0x00000000, status=0100.
REQ-035 A=0x3E000000, B=0x0A000000 (half ulp, tie), add -> data_out=0x3E000000, status=1000 (both macro settings).
REQ-036 start pulsed again 2 cycles after an accepted start, then reset asserted mid-NORM -> second start ignored; after reset ready=1, data_out=0, status=0000.
